// File: rtl/vga_sprite_render_if.sv
// Signal bundle between the VGA timing generator / board pins and the sprite renderer.
// The master side drives counters, syncs and buttons; the slave side returns colour and delayed syncs.
interface vga_sprite_render_if;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       vidon;
    logic       hsync_in;
    logic       vsync_in;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       auto_mode;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;

    modport master (
        output hc, vc, vidon, hsync_in, vsync_in,
        output btn_up, btn_down, btn_left, btn_right, auto_mode,
        input  red, green, blue, hsync, vsync, frame_tick
    );

    modport slave (
        input  hc, vc, vidon, hsync_in, vsync_in,
        input  btn_up, btn_down, btn_left, btn_right, auto_mode,
        output red, green, blue, hsync, vsync, frame_tick
    );
endinterface

// File: rtl/vga_sprite_render.sv
// Renders one square sprite plus a 1-pixel screen border over the 640x480 VGA raster.
// The sprite moves once per frame, either by buttons (clamped) or bouncing off the edges.
module vga_sprite_render #(
    parameter int          SIZE       = 16,
    parameter int          STEP       = 2,
    parameter int          HBP        = 144,
    parameter int          VBP        = 31,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter logic [11:0] SPR_RGB    = 12'hF80,
    parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
    input  logic              clk25,
    input  logic              rst_n,
    vga_sprite_render_if.slave vga
);

    localparam logic [9:0]  HBP10  = 10'(HBP);
    localparam logic [9:0]  VBP10  = 10'(VBP);
    localparam logic [10:0] SIZE11 = 11'(SIZE);
    localparam int          NSYNC  = 5;

    typedef enum logic {MANUAL = 1'b0, BOUNCE = 1'b1} state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers: {auto_mode, right, left, down, up}
    // ------------------------------------------------------------------
    logic [NSYNC-1:0] async_in;
    logic [NSYNC-1:0] sync_bits;

    assign async_in = {vga.auto_mode, vga.btn_right, vga.btn_left, vga.btn_down, vga.btn_up};

    generate
        for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk25) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic up_s, down_s, left_s, right_s, auto_s;
    assign {auto_s, right_s, left_s, down_s, up_s} = sync_bits;

    // ------------------------------------------------------------------
    // Frame tick and mode state machine
    // ------------------------------------------------------------------
    logic   tick_now;
    state_t state_reg, state_next;

    assign tick_now = (vga.hc == 10'd799) && (vga.vc == 10'd520);

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_reg <= MANUAL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (tick_now) begin
            state_next = auto_s ? BOUNCE : MANUAL;
        end
    end

    // ------------------------------------------------------------------
    // Per-axis position and direction (axis 0 = x, axis 1 = y)
    // ------------------------------------------------------------------
    logic [1:0][9:0] pos;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int          LIM_I = (gi == 0) ? (640 - SIZE) : (480 - SIZE);
            localparam logic [9:0]  LIM   = 10'(LIM_I);
            localparam logic [9:0]  START = 10'(LIM_I / 2);
            localparam logic signed [10:0] LIM11  = 11'(LIM_I);
            localparam logic signed [10:0] STEP11 = 11'(STEP);

            logic dec_btn, inc_btn;
            logic [9:0] pos_reg, pos_next;
            logic dir_reg, dir_next;
            logic signed [10:0] inc_val, dec_val;
            logic over, under;

            assign dec_btn = (gi == 0) ? left_s  : up_s;
            assign inc_btn = (gi == 0) ? right_s : down_s;

            // Signed 11-bit candidates so neither direction can wrap.
            assign inc_val = $signed({1'b0, pos_reg}) + STEP11;
            assign dec_val = $signed({1'b0, pos_reg}) - STEP11;
            assign over    = inc_val > LIM11;
            assign under   = dec_val[10];

            always_comb begin
                pos_next = pos_reg;
                dir_next = dir_reg;
                if (tick_now) begin
                    if (state_next == BOUNCE) begin
                        if (dir_reg) begin
                            if (over) begin
                                pos_next = LIM;
                                dir_next = 1'b0;
                            end else begin
                                pos_next = inc_val[9:0];
                            end
                        end else begin
                            if (under) begin
                                pos_next = 10'd0;
                                dir_next = 1'b1;
                            end else begin
                                pos_next = dec_val[9:0];
                            end
                        end
                    end else if (dec_btn && !inc_btn) begin
                        pos_next = under ? 10'd0 : dec_val[9:0];
                    end else if (inc_btn && !dec_btn) begin
                        pos_next = over ? LIM : inc_val[9:0];
                    end
                end
            end

            always_ff @(posedge clk25) begin
                if (!rst_n) begin
                    pos_reg <= START;
                    dir_reg <= 1'b1;
                end else begin
                    pos_reg <= pos_next;
                    dir_reg <= dir_next;
                end
            end

            assign pos[gi] = pos_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    logic [9:0]  px, py;
    logic        spr_hit, border_hit;
    logic [11:0] rgb_next, rgb_reg;
    logic        hsync_reg, vsync_reg, tick_reg;

    assign px = vga.hc - HBP10;
    assign py = vga.vc - VBP10;

    assign spr_hit = (px >= pos[0]) && ({1'b0, px} < ({1'b0, pos[0]} + SIZE11)) &&
                     (py >= pos[1]) && ({1'b0, py} < ({1'b0, pos[1]} + SIZE11));

    assign border_hit = (px == 10'd0) || (px == 10'd639) || (py == 10'd0) || (py == 10'd479);

    always_comb begin
        rgb_next = 12'h000;
        if (vga.vidon) begin
            if (spr_hit) begin
                rgb_next = SPR_RGB;
            end else if (border_hit) begin
                rgb_next = BORDER_RGB;
            end else begin
                rgb_next = BG_RGB;
            end
        end
    end

    // Syncs ride one register stage so they line up with the colour.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            rgb_reg   <= 12'h000;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            tick_reg  <= 1'b0;
        end else begin
            rgb_reg   <= rgb_next;
            hsync_reg <= vga.hsync_in;
            vsync_reg <= vga.vsync_in;
            tick_reg  <= tick_now;
        end
    end

    assign vga.red        = rgb_reg[11:8];
    assign vga.green      = rgb_reg[7:4];
    assign vga.blue       = rgb_reg[3:0];
    assign vga.hsync      = hsync_reg;
    assign vga.vsync      = vsync_reg;
    assign vga.frame_tick = tick_reg;

endmodule

// File: tb/tb_vga_sprite_render.sv
// Randomized scoreboard bench for vga_sprite_render: the driver pushes the expected
// pixel output for every cycle it drives, an independent monitor pops and compares.
module tb_vga_sprite_render;

    localparam int SIZE = 16;
    localparam int STEP = 2;
    localparam int XMAX = 640 - SIZE;
    localparam int YMAX = 480 - SIZE;

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk25 = ~clk25;

    vga_sprite_render_if vif ();

    vga_sprite_render dut (
        .clk25 (clk25),
        .rst_n (rst_n),
        .vga   (vif)
    );

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        tick;
    } exp_t;

    exp_t expq[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   driving_done = 0;

    // Reference model: sprite position, bounce directions, button history.
    int       mx, my;
    bit       mdx, mdy;
    bit [4:0] hist [3];   // [0] newest; bits {auto,right,left,down,up}
    bit [4:0] cur_btn;

    function automatic logic [11:0] ref_rgb(int h, int v, bit vid);
        int px, py;
        if (!vid) return 12'h000;
        px = (h - 144) & 1023;
        py = (v - 31) & 1023;
        if (px >= mx && px < mx + SIZE && py >= my && py < my + SIZE) return 12'hF80;
        if (px == 0 || px == 639 || py == 0 || py == 479) return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic bounce(inout int p, inout bit d, input int lim);
        int n;
        n = d ? p + STEP : p - STEP;
        if (n > lim) begin p = lim; d = 0; end
        else if (n < 0) begin p = 0; d = 1; end
        else p = n;
    endtask

    task automatic clamp_move(inout int p, input bit dec, input bit inc, input int lim);
        if (dec && !inc) p = (p - STEP < 0) ? 0 : p - STEP;
        else if (inc && !dec) p = (p + STEP > lim) ? lim : p + STEP;
    endtask

    task automatic model_tick(input bit [4:0] s);
        if (s[4]) begin
            bounce(mx, mdx, XMAX);
            bounce(my, mdy, YMAX);
        end else begin
            clamp_move(mx, s[2], s[3], XMAX);
            clamp_move(my, s[0], s[1], YMAX);
        end
    endtask

    task automatic model_reset();
        mx = (640 - SIZE) / 2;
        my = (480 - SIZE) / 2;
        mdx = 1;
        mdy = 1;
    endtask

    // One driven cycle; expectation for the following clock edge goes into the queue.
    task automatic drive(input bit rst, input int h, input int v, input bit vid);
        exp_t e;
        bit hs, vs;
        hs = 1'($urandom);
        vs = 1'($urandom);
        @(negedge clk25);
        rst_n         = !rst;
        vif.hc        = 10'(h);
        vif.vc        = 10'(v);
        vif.vidon     = vid;
        vif.hsync_in  = hs;
        vif.vsync_in  = vs;
        {vif.auto_mode, vif.btn_right, vif.btn_left, vif.btn_down, vif.btn_up} = cur_btn;
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (rst) begin
            hist[0] = '0;
            model_reset();
            e.rgb = 12'h000; e.hs = 1; e.vs = 1; e.tick = 0;
        end else begin
            hist[0] = cur_btn;
            e.rgb  = ref_rgb(h, v, vid);
            e.hs   = hs;
            e.vs   = vs;
            e.tick = (h == 799 && v == 520);
            if (e.tick) model_tick(hist[2]);
        end
        expq.push_back(e);
    endtask

    task automatic rand_pixel();
        int r, h, v;
        bit vid;
        r = int'($urandom_range(0, 9));
        if (r <= 3) begin
            h = 144 + mx + int'($urandom_range(0, SIZE + 1)) - 1;
            v = 31 + my + int'($urandom_range(0, SIZE + 1)) - 1;
            if (h < 144) h = 144;
            if (h > 783) h = 783;
            if (v < 31) v = 31;
            if (v > 510) v = 510;
            vid = 1;
        end else if (r <= 5) begin
            h = $urandom_range(0, 1) ? 144 : 783;
            v = int'($urandom_range(31, 510));
            if ($urandom_range(0, 1) == 1) begin
                h = int'($urandom_range(144, 783));
                v = $urandom_range(0, 1) ? 31 : 510;
            end
            vid = 1;
        end else if (r <= 8) begin
            h = int'($urandom_range(144, 783));
            v = int'($urandom_range(31, 510));
            vid = 1;
        end else begin
            h = int'($urandom_range(0, 798));
            v = int'($urandom_range(0, 520));
            vid = 0;
        end
        drive(0, h, v, vid);
    endtask

    // A compressed frame: buttons btn_a for na pixels, then btn_b for nb pixels, then the tick.
    task automatic frame(input bit [4:0] btn_a, input int na, input bit [4:0] btn_b, input int nb);
        cur_btn = btn_a;
        repeat (na) rand_pixel();
        cur_btn = btn_b;
        repeat (nb) rand_pixel();
        drive(0, 799, 520, 0);
    endtask

    // Explicit sprite-corner and edge probes against the current model position.
    task automatic probe_sprite();
        drive(0, 144 + mx, 31 + my, 1);
        drive(0, 143 + mx + SIZE, 30 + my + SIZE, 1);
        drive(0, 144 + mx + SIZE, 31 + my, 1);
        drive(0, 144 + mx, 31 + my + SIZE, 1);
    endtask

    // Monitor: one comparison per cycle with a pending expectation.
    initial begin
        exp_t e;
        logic [11:0] got;
        forever begin
            @(posedge clk25);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                got = {vif.red, vif.green, vif.blue};
                vectors++;
                if (got !== e.rgb || vif.hsync !== e.hs || vif.vsync !== e.vs ||
                    vif.frame_tick !== e.tick) begin
                    miscompares++;
                    $display("FAIL pixel_out vec %0d: got rgb=%h hs=%b vs=%b tick=%b, want rgb=%h hs=%b vs=%b tick=%b (model x=%0d y=%0d)",
                             vectors, got, vif.hsync, vif.vsync, vif.frame_tick,
                             e.rgb, e.hs, e.vs, e.tick, mx, my);
                end
            end
        end
    end

    initial begin
        cur_btn = '0;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        model_reset();
        vif.hc = '0; vif.vc = '0; vif.vidon = 0;
        vif.hsync_in = 1; vif.vsync_in = 1;
        {vif.auto_mode, vif.btn_right, vif.btn_left, vif.btn_down, vif.btn_up} = '0;

        repeat (3) drive(1, 0, 0, 0);

        // Idle frames: nothing moves; probe sprite, border and vidon=0.
        repeat (3) begin
            frame(5'b00000, 6, 5'b00000, 2);
            probe_sprite();
            drive(0, 144, 200, 1);
            drive(0, 400, 300, 1);
            drive(0, 400, 300, 0);
        end

        // Right held long enough to clamp at XMAX.
        repeat (200) frame(5'b01000, 3, 5'b01000, 1);
        probe_sprite();
        // Left and right together: no movement.
        repeat (5) frame(5'b01100, 3, 5'b01100, 1);
        probe_sprite();
        // Up held until y clamps at 0.
        repeat (125) frame(5'b00001, 3, 5'b00001, 1);
        probe_sprite();

        // Random button combinations, including a change right before the tick.
        repeat (150) frame(5'($urandom_range(0, 15)), 3, 5'($urandom_range(0, 15)),
                           int'($urandom_range(0, 3)));

        // Reset mid-frame, then bounce from the reset position.
        cur_btn = 5'b10000;
        rand_pixel();
        repeat (2) drive(1, 300, 100, 1);
        repeat (400) begin
            frame(5'b10000, 3, 5'b10000, 1);
            if ($urandom_range(0, 7) == 0) probe_sprite();
        end

        // Mode toggled mid-frame, sometimes within the synchroniser window.
        repeat (150) frame(5'($urandom_range(0, 31)), 3, 5'($urandom_range(0, 31)),
                           int'($urandom_range(0, 3)));
        probe_sprite();

        repeat (3) @(posedge clk25);
        #2;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
